// File: rtl/resp_tx_pkg.sv
// Shared types and constants for the BLE response transmitter.
// No logic of its own: state encoding, queue depth and the fast-sim divisor.
package resp_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FIFO_DEPTH   = 4;
  localparam int FAST_SIM_DIV = 16;

  function automatic int eff_div(input int baud_div, input bit fast_sim);
    return fast_sim ? FAST_SIM_DIV : baud_div;
  endfunction

endpackage

// File: rtl/resp_tx_if.sv
// Response strobe/byte in, serial line and status out, between cmd_proc and resp_tx.
// Wires only, so no latency; there is no backpressure, and full/ovfl report drops.
interface resp_tx_if;

  logic       send_resp;
  logic [7:0] resp;
  logic       TX;
  logic       tx_done;
  logic       busy;
  logic       full;
  logic       ovfl;

  modport master (
    output send_resp, resp,
    input  TX, tx_done, busy, full, ovfl
  );

  modport slave (
    input  send_resp, resp,
    output TX, tx_done, busy, full, ovfl
  );

endinterface

// File: rtl/resp_tx_fifo.sv
// 4x8 response queue with wrapping 2-bit pointers, a 3-bit count and a sticky overflow flag.
// A push takes one edge and the head is readable combinationally; a push while full is dropped.
module resp_fifo
  import resp_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_push_dat,
  input  logic       i_pop,
  output logic [7:0] o_head_dat,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_ovfl,
  output logic [2:0] o_count
);

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic       r_full;
  logic       r_ovfl;

  logic       w_wr;
  logic       w_rd;
  logic [2:0] w_count_nxt;

  // Fullness comes from the registered count, so a pop on the same edge cannot rescue a push.
  assign w_wr = i_push & ~r_full;
  assign w_rd = i_pop & (r_count != 3'd0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + 3'd1;
      2'b01:   w_count_nxt = r_count - 3'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
      r_full  <= 1'b0;
      r_ovfl  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_rd) begin
        r_rptr <= r_rptr + 2'd1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == 3'(FIFO_DEPTH));
      if (i_push && r_full) begin
        r_ovfl <= 1'b1;
      end
    end
  end

  assign o_head_dat = r_mem[r_rptr];
  assign o_empty    = (r_count == 3'd0);
  assign o_full     = r_full;
  assign o_ovfl     = r_ovfl;
  assign o_count    = r_count;

endmodule

// File: rtl/resp_tx.sv
// UART 8N1 (LSB first) response transmitter fed from a 4-deep byte queue.
// TX falls two edges after the strobe; frames run gapless; strobes into a full queue are dropped.
module resp_tx
  import resp_tx_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter bit FAST_SIM = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  resp_tx_if.slave  bus
);

  localparam int          DIV       = eff_div(BAUD_DIV, FAST_SIM);
  localparam logic [11:0] BAUD_LAST = 12'(DIV - 1);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [11:0] r_baud;
  logic [11:0] w_baud_nxt;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_nxt;
  logic [9:0]  r_shift;
  logic [9:0]  w_shift_nxt;
  logic        r_tx;
  logic        r_leave;
  logic        r_tx_done;

  logic        w_tick;
  logic        w_load;
  logic        w_leave;
  logic [7:0]  w_head_dat;
  logic        w_empty;
  logic        w_full;
  logic        w_ovfl;
  logic [2:0]  w_count;

  resp_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (bus.send_resp),
    .i_push_dat (bus.resp),
    .i_pop      (w_load),
    .o_head_dat (w_head_dat),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_ovfl     (w_ovfl),
    .o_count    (w_count)
  );

  assign w_tick = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_load        = 1'b0;
    w_leave       = 1'b0;

    if (r_state != IDLE) begin
      w_baud_nxt = w_tick ? 12'd0 : r_baud + 12'd1;
    end

    case (r_state)
      IDLE: begin
        w_load = ~w_empty;
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_shift_nxt = {1'b1, r_shift[9:1]};
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt   = {1'b1, r_shift[9:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_leave     = 1'b1;
          w_state_nxt = IDLE;
          w_load      = ~w_empty;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Popping the head also starts the next frame, which is what keeps STOP->START gapless.
    if (w_load) begin
      w_state_nxt   = START;
      w_shift_nxt   = {1'b1, w_head_dat, 1'b0};
      w_baud_nxt    = 12'd0;
      w_bit_idx_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_baud    <= 12'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 10'h3FF;
      r_tx      <= 1'b1;
      r_leave   <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= (r_state == IDLE) ? 1'b1 : r_shift[0];
      // The line lags the FSM by one flop, so the done pulse is delayed to match it.
      r_leave   <= w_leave;
      r_tx_done <= r_leave;
    end
  end

  assign bus.TX      = r_tx;
  assign bus.tx_done = r_tx_done;
  assign bus.busy    = (r_state != IDLE) | (w_count != 3'd0);
  assign bus.full    = w_full;
  assign bus.ovfl    = w_ovfl;

endmodule

// File: tb/tb_resp_tx.sv
// Directed bench for resp_tx: a fast-divisor instance for framing/queue tests and a default-divisor one for frame length.
// Expected bit patterns, cycle positions and flag values are worked out by hand from the timing rules.
module tb_resp_tx;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  resp_tx_if bus_a ();
  resp_tx_if bus_b ();

  resp_tx #(.BAUD_DIV(2604), .FAST_SIM(1'b1)) u_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  resp_tx #(.BAUD_DIV(2604), .FAST_SIM(1'b0)) u_dflt (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  logic [7:0] wrap_bytes [10] = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h33,
                                  8'hCC, 8'h0F, 8'hF0, 8'h96, 8'h69};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe_a(input logic [7:0] b);
    bus_a.send_resp = 1'b1;
    bus_a.resp      = b;
    @(negedge clk);
    bus_a.send_resp = 1'b0;
  endtask

  // Leaves the caller on the negedge of the first start-bit cycle.
  task automatic strobe_align_a(input logic [7:0] b, input string tag);
    strobe_a(b);
    chk($sformatf("%s tx_e0", tag), bus_a.TX, 1'b1);
    @(negedge clk);
    chk($sformatf("%s tx_e1", tag), bus_a.TX, 1'b1);
    @(negedge clk);
  endtask

  // Entered on the first start-bit cycle; returns on the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input logic first_done, input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s b%0d first", tag, i), bus_a.TX, fr[i]);
      chk($sformatf("%s b%0d done", tag, i), bus_a.tx_done, (i == 0) ? first_done : 1'b0);
      repeat (15) @(negedge clk);
      chk($sformatf("%s b%0d last", tag, i), bus_a.TX, fr[i]);
      @(negedge clk);
    end
  endtask

  task automatic uart_rx(output logic [7:0] b, output logic ok);
    int n;
    ok = 1'b0;
    b  = 8'h00;
    n  = 0;
    while (bus_a.TX !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.TX !== 1'b0) return;
    repeat (8) @(negedge clk);
    if (bus_a.TX !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      b[i] = bus_a.TX;
    end
    repeat (16) @(negedge clk);
    ok = (bus_a.TX === 1'b1);
  endtask

  task automatic wait_done(output logic seen);
    int n;
    n = 0;
    while (bus_a.tx_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    seen = (bus_a.tx_done === 1'b1);
  endtask

  initial begin
    logic [7:0] rx_b;
    logic       rx_ok;
    logic       seen;
    int         cnt;

    rst_n           = 1'b0;
    bus_a.send_resp = 1'b0;
    bus_a.resp      = 8'h00;
    bus_b.send_resp = 1'b0;
    bus_b.resp      = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst tx", bus_a.TX, 1'b1);
    chk("rst tx_done", bus_a.tx_done, 1'b0);
    chk("rst busy", bus_a.busy, 1'b0);
    chk("rst full", bus_a.full, 1'b0);
    chk("rst ovfl", bus_a.ovfl, 1'b0);
    chk("rst tx dflt", bus_b.TX, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle tx", bus_a.TX, 1'b1);

    // Single byte 0xA5
    strobe_align_a(8'hA5, "single");
    chk("single busy", bus_a.busy, 1'b1);
    check_frame(8'hA5, 1'b0, "single");
    chk("single done", bus_a.tx_done, 1'b1);
    chk("single busy end", bus_a.busy, 1'b0);
    chk("single tx end", bus_a.TX, 1'b1);
    @(negedge clk);
    chk("single done clr", bus_a.tx_done, 1'b0);
    chk("single full", bus_a.full, 1'b0);
    chk("single ovfl", bus_a.ovfl, 1'b0);
    repeat (5) @(negedge clk);

    // Gapless queue 0x01, 0x02, 0x03
    bus_a.send_resp = 1'b1;
    bus_a.resp      = 8'h01;
    @(negedge clk);
    bus_a.resp      = 8'h02;
    @(negedge clk);
    bus_a.resp      = 8'h03;
    @(negedge clk);
    bus_a.send_resp = 1'b0;
    check_frame(8'h01, 1'b0, "gap1");
    check_frame(8'h02, 1'b1, "gap2");
    check_frame(8'h03, 1'b1, "gap3");
    chk("gap done", bus_a.tx_done, 1'b1);
    chk("gap busy", bus_a.busy, 1'b0);
    repeat (5) @(negedge clk);

    // Overflow: 0x10..0x15 on consecutive clocks, 0x15 dropped
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          bus_a.send_resp = 1'b1;
          bus_a.resp      = 8'h10 + 8'(k);
          @(negedge clk);
          if (k == 3) chk("ovf full after 4th", bus_a.full, 1'b0);
          if (k == 4) chk("ovf full after 5th", bus_a.full, 1'b1);
          if (k == 4) chk("ovf ovfl before 6th", bus_a.ovfl, 1'b0);
          if (k == 5) chk("ovf ovfl after 6th", bus_a.ovfl, 1'b1);
        end
        bus_a.send_resp = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        check_frame(8'h10, 1'b0, "ovf10");
        check_frame(8'h11, 1'b1, "ovf11");
        check_frame(8'h12, 1'b1, "ovf12");
        check_frame(8'h13, 1'b1, "ovf13");
        check_frame(8'h14, 1'b1, "ovf14");
      end
    join
    chk("ovf done", bus_a.tx_done, 1'b1);
    chk("ovf busy", bus_a.busy, 1'b0);
    chk("ovf full end", bus_a.full, 1'b0);
    chk("ovf ovfl sticky", bus_a.ovfl, 1'b1);
    repeat (4) @(negedge clk);
    chk("ovf no 0x15 frame", bus_a.TX, 1'b1);

    // Pointer wrap: ten spaced bytes through a UART receiver
    for (int k = 0; k < 10; k++) begin
      strobe_a(wrap_bytes[k]);
      chk($sformatf("wrap%0d full", k), bus_a.full, 1'b0);
      uart_rx(rx_b, rx_ok);
      chk($sformatf("wrap%0d framing", k), rx_ok, 1'b1);
      chk($sformatf("wrap%0d byte", k), rx_b, wrap_bytes[k]);
      wait_done(seen);
      chk($sformatf("wrap%0d done", k), seen, 1'b1);
      chk($sformatf("wrap%0d busy", k), bus_a.busy, 1'b0);
      chk($sformatf("wrap%0d full end", k), bus_a.full, 1'b0);
    end
    chk("wrap ovfl sticky", bus_a.ovfl, 1'b1);
    repeat (3) @(negedge clk);

    // Reset in the middle of data bit 3 of 0xE7 (bit 3 = 0)
    strobe_align_a(8'hE7, "rstmid");
    chk("rstmid start", bus_a.TX, 1'b0);
    repeat (69) @(negedge clk);
    chk("rstmid bit3", bus_a.TX, 1'b0);
    chk("rstmid busy pre", bus_a.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid tx async", bus_a.TX, 1'b1);
    chk("rstmid busy async", bus_a.busy, 1'b0);
    chk("rstmid done async", bus_a.tx_done, 1'b0);
    chk("rstmid full async", bus_a.full, 1'b0);
    chk("rstmid ovfl cleared", bus_a.ovfl, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid idle", bus_a.TX, 1'b1);
    strobe_align_a(8'h3C, "post");
    check_frame(8'h3C, 1'b0, "post");
    chk("post done", bus_a.tx_done, 1'b1);
    chk("post busy", bus_a.busy, 1'b0);
    repeat (3) @(negedge clk);

    // Default divisor: frame of 0x55 measured from TX fall to tx_done
    bus_b.send_resp = 1'b1;
    bus_b.resp      = 8'h55;
    @(negedge clk);
    bus_b.send_resp = 1'b0;
    cnt = 0;
    while (bus_b.TX !== 1'b0 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("dflt fall latency", cnt, 2);
    cnt = 0;
    while (bus_b.tx_done !== 1'b1 && cnt < 30000) begin
      @(negedge clk);
      cnt++;
    end
    chk("dflt frame length", cnt, 26040);
    chk("dflt busy", bus_b.busy, 1'b0);
    chk("dflt tx idle", bus_b.TX, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/resp_tx.md
# resp_tx

Response transmitter for the MazeRunner BLE link: the TX-side counterpart of the command receive path. It accepts one-byte responses (acks, status codes) from command processing via a `send_resp` strobe and buffers them in a 4-entry FIFO. It serializes them as UART 8N1, LSB first, on `TX` to the BLE module. It sits beside `cmd_proc` in the top level and drives the previously unconnected `send_resp` path.

## Interface
- `BAUD_DIV`, 2604: clocks per bit; 2604 gives 19200 baud at 50 MHz. Legal range 4..4095.
- `FAST_SIM`, 0: when 1, the effective divisor is 16, overriding `BAUD_DIV`.
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low (already decided).
- `send_resp` in 1: single-cycle strobe that enqueues `resp`.
- `resp` in 8: response byte, sampled on the edge where `send_resp`=1.
- `TX` out 1: serial line to BLE; idles high.
- `tx_done` out 1: one-clock pulse at the end of each frame's stop bit.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `full` out 1: FIFO holds 4 entries.
- `ovfl` out 1: sticky; set when a strobe is dropped; cleared only by reset.

## Operation
- **FIFO:** 4×8, with 2-bit read/write pointers that wrap modulo 4 and a 3-bit count.
  - A write while `full`=1 (count sampled before the edge) is dropped and sets `ovfl`. This holds even if a pop occurs on the same edge.
  - A simultaneous push and pop when not full leaves the count unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge: pop the head into a 10-bit shift register {1, byte, 0}, clear the baud counter, and set the bit index to 0.
  - START → DATA after `BAUD_DIV` clocks.
  - DATA → STOP after 8 bits; the bit index advances every `BAUD_DIV` clocks.
  - STOP → IDLE after `BAUD_DIV` clocks with the FIFO empty.
  - STOP → START directly if the FIFO is non-empty. The pop happens on the same edge, so frames are gapless.
- **`TX`:** driven from a flop, never combinationally. It equals the shift-register LSB while in START/DATA/STOP and 1 in IDLE.
- **Counters:** the baud counter is 12 bits and counts 0..`BAUD_DIV`−1. Reaching terminal count produces a bit tick.
- **`tx_done`:** asserted on the edge leaving STOP.
- **`busy`:** `busy` = (state≠IDLE) | (count≠0).
- **Reset mid-frame:** immediately forces `TX`=1 and IDLE, and empties the FIFO. A partial frame is abandoned; the BLE side sees a framing error, which is acceptable.
- **Reset values:** `TX`=1, `tx_done`=0, `busy`=0, `full`=0, `ovfl`=0.

## Timing
- **Latency from idle:** `send_resp` is sampled at edge E0. The FIFO is non-empty after E0. IDLE→START and the pop occur at E1. `TX` falls at E2.
- **Bit width:** each bit, including start and stop, lasts exactly `BAUD_DIV` clocks. A frame is 10×`BAUD_DIV` clocks.
- **`tx_done`:** high for the single cycle following the final clock of the stop bit.
- **Back-to-back frames:** the next start bit begins in that same cycle (no idle bit).
- **Throughput:** one byte per 10×`BAUD_DIV` clocks. Up to 4 queued bytes plus 1 in flight are lossless.
- **`full`:** updates on the edge after the write that fills the FIFO; it is a registered count compare.

## Structure
- **Package `resp_tx_pkg`:** state enum `tx_state_t` {IDLE, START, DATA, STOP}, `FIFO_DEPTH`=4, and the `FAST_SIM` divisor constant 16.
- **Sub-module `resp_fifo`:** holds the FIFO (storage, pointers, count, full/empty). The top of `resp_tx` contains the FSM, baud counter, bit index, and shift register.

## Test plan
- **Single byte:** `FAST_SIM`=1, one strobe with 0xA5.
  - `TX` falls 2 clocks later.
  - Bits 1,0,1,0,0,1,0,1, then stop, each 16 clocks.
  - `tx_done` pulses once, then `busy`=0.
- **Gapless queue:** strobes on consecutive clocks with 0x01, 0x02, 0x03.
  - Three frames with no idle between stop and start.
  - Three `tx_done` pulses, 160 clocks apart.
- **Overflow:** six strobes on consecutive clocks with 0x10..0x15.
  - One byte in flight plus 4 in the FIFO.
  - 0x15 is dropped and `ovfl`=1.
  - 0x10..0x14 are transmitted in order.
  - `full` is 1 after the 5th strobe.
- **Pointer wrap:** 10 bytes with spaced strobes (one per frame).
  - All bytes are received correctly by a bench UART model.
  - `full` never asserts.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3.
  - `TX`=1 and `busy`=0 immediately, not on the next edge.
  - After release, a new 0x3C strobe transmits cleanly.
- **Default divisor:** `FAST_SIM`=0, `BAUD_DIV`=2604, one 0x55 strobe.
  - Frame length is exactly 26040 clocks, measured `TX` fall to `tx_done`.
